// File: rtl/bootram_bus_ctrl_pkg.sv
// bootram_pkg: shared state encoding and sizing for the boot RAM bus controller
package bootram_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, CAPTURE = 2'd2, RESP = 2'd3} state_t;
  localparam int BOOTRAM_BYTES = 8192;
  localparam int LANES_DEF = 4;
  localparam int AW_DEF = $clog2(BOOTRAM_BYTES / LANES_DEF);
endpackage

// File: rtl/bootram_bus_ctrl_if.sv
// bootram_bus_ctrl_if: PicoRV32 native memory bus as seen by the boot RAM slave
interface bootram_bus_ctrl_if;
  logic        mem_valid;
  logic        mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  modport master (output mem_valid, mem_sel, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata);
  modport slave (input mem_valid, mem_sel, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/bootram_bus_ctrl_lane_mux.sv
// bootram_lane_mux: splits bus write data/strobes into byte lanes and reassembles lane read data
module bootram_lane_mux
  import bootram_pkg::*;
#(parameter int LANES = LANES_DEF) (
  input  logic [8*LANES-1:0] wdata,
  input  logic [LANES-1:0]   wstrb,
  input  logic               we,
  input  logic [8*LANES-1:0] ram_dout,
  output logic [8*LANES-1:0] lane_din,
  output logic [LANES-1:0]   lane_wre,
  output logic [8*LANES-1:0] rdata
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_din[8*i +: 8] = wdata[8*i +: 8];
    assign lane_wre[i]        = wstrb[i] & we;
    assign rdata[8*i +: 8]    = ram_dout[8*i +: 8];
  end
endmodule

// File: rtl/bootram_bus_ctrl.sv
// bootram_bus_ctrl: PicoRV32 slave driving four byte-lane boot RAM macros with registered pins.
// Define BOOTRAM_WP_EN to add the wp input and wp_err output (write protect).
module bootram_bus_ctrl
  import bootram_pkg::*;
#(parameter int AW = AW_DEF, parameter int LANES = LANES_DEF) (
  input  logic               clk,
  input  logic               reset,
  bootram_bus_ctrl_if.slave  bus,
  output logic [AW-1:0]      ram_ad,
  output logic [8*LANES-1:0] ram_din,
  output logic               ram_ce,
  output logic               ram_oce,
  output logic [LANES-1:0]   ram_wre,
`ifdef BOOTRAM_WP_EN
  input  logic               wp,
  output logic               wp_err,
`endif
  input  logic [8*LANES-1:0] ram_dout
);
  state_t state, state_n;
  logic accept, wr_q, we_en, unused_addr;
  logic [8*LANES-1:0] lane_din, lane_rdata, rdata_q;
  logic [LANES-1:0] lane_wre;
`ifdef BOOTRAM_WP_EN
  logic wp_q;
`endif
  assign ram_oce = 1'b1;
  assign bus.mem_rdata = rdata_q;
  assign unused_addr = ^{bus.mem_addr[31:AW+2], bus.mem_addr[1:0]};
  bootram_lane_mux #(.LANES(LANES)) u_lane_mux (
    .wdata(bus.mem_wdata),
    .wstrb(bus.mem_wstrb),
    .we(we_en),
    .ram_dout(ram_dout),
    .lane_din(lane_din),
    .lane_wre(lane_wre),
    .rdata(lane_rdata)
  );
  always_comb begin
    accept = state == IDLE && bus.mem_valid && bus.mem_sel;
    state_n = state == IDLE ? (accept ? ACCESS : IDLE) :
              state == ACCESS ? (wr_q ? RESP : CAPTURE) :
              state == CAPTURE ? RESP : IDLE;
    bus.mem_ready = state == RESP;
`ifdef BOOTRAM_WP_EN
    we_en = !wp;
    wp_err = state == RESP && wp_q;
`else
    we_en = 1'b1;
`endif
  end
  // RAM pins are loaded on the accepting edge so they are stable for the whole ACCESS cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rdata_q <= '0;
      ram_ce  <= 1'b0;
      ram_wre <= '0;
      ram_ad  <= '0;
      ram_din <= '0;
      wr_q    <= 1'b0;
`ifdef BOOTRAM_WP_EN
      wp_q    <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      ram_ce  <= accept;
      ram_wre <= accept ? lane_wre : '0;
      if (accept) begin
        ram_ad  <= bus.mem_addr[AW+1:2];
        ram_din <= lane_din;
        wr_q    <= |bus.mem_wstrb;
`ifdef BOOTRAM_WP_EN
        wp_q    <= wp && |bus.mem_wstrb;
`endif
      end
      if (state == CAPTURE) rdata_q <= lane_rdata;
    end
  end
endmodule

// File: tb/tb_bootram_bus_ctrl.sv
// tb_bootram_bus_ctrl: table-driven bench with a byte-lane RAM model and a response scoreboard
module tb_bootram_bus_ctrl;
  import bootram_pkg::*;
  localparam int AW = 11;
  typedef struct {
    logic        rd;
    logic [31:0] rdata;
    int          cyc;
    logic        wperr;
  } exp_t;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  exp_wre;
    logic [31:0] exp_rdata;
  } vec_t;
  logic clk = 0, reset = 1;
  logic [AW-1:0] ram_ad;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = 32'h0;
  logic ram_ce, ram_oce;
  logic [3:0] ram_wre;
`ifdef BOOTRAM_WP_EN
  logic wp = 1'b0, wp_err;
`endif
  logic [31:0] mem [2**AW] = '{default: 32'h0};
  exp_t sb[$];
  vec_t vecs [11];
  int cyc = 0, checks = 0, fails = 0;
  bootram_bus_ctrl_if bus();
  bootram_bus_ctrl #(.AW(AW), .LANES(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .ram_ad(ram_ad),
    .ram_din(ram_din),
    .ram_ce(ram_ce),
    .ram_oce(ram_oce),
    .ram_wre(ram_wre),
`ifdef BOOTRAM_WP_EN
    .wp(wp),
    .wp_err(wp_err),
`endif
    .ram_dout(ram_dout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // four 2Kx8 lanes in bypass read mode: data read on an enabled edge appears the next cycle
  always @(posedge clk) begin
    if (ram_ce) begin
      for (int n = 0; n < 4; n++)
        if (ram_wre[n]) mem[ram_ad][8*n +: 8] <= ram_din[8*n +: 8];
      ram_dout <= mem[ram_ad];
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && bus.mem_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_ready: got mem_ready=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ready_latency", cyc, e.cyc);
        if (e.rd) chk("rdata", bus.mem_rdata, e.rdata);
`ifdef BOOTRAM_WP_EN
        chk("wp_err", {31'b0, wp_err}, {31'b0, e.wperr});
`endif
      end
    end
  end
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input logic [3:0] exp_wre, input logic [31:0] exp_rdata, input logic wpv = 1'b0);
    int st;
    bit done;
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b1;
    bus.mem_sel   = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
`ifdef BOOTRAM_WP_EN
    wp = wpv;
`endif
    st = cyc;
    sb.push_back('{!wr, exp_rdata, st + (wr ? 2 : 3), wpv && wr});
    done = 0;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge clk);
      if (cyc == st + 1) begin
        chk("access_ce", {31'b0, ram_ce}, 32'h1);
        chk("access_wre", {28'b0, ram_wre}, {28'b0, exp_wre});
        chk("access_ad", {21'b0, ram_ad}, {21'b0, addr[AW+1:2]});
        if (wr) chk("access_din", ram_din, wdata);
      end
      if (cyc == st + 2) chk("ce_after_access", {31'b0, ram_ce}, 32'h0);
      done = bus.mem_ready === 1'b1;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: got no mem_ready expected one within 8 cycles (addr 0x%0h)", addr);
    end
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    bus.mem_sel   = 1'b0;
    bus.mem_wstrb = 4'h0;
`ifdef BOOTRAM_WP_EN
    wp = 1'b0;
`endif
  endtask
  initial begin
    int st;
    vecs = '{
      '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 4'hF, 32'h0},
      '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 4'h0, 32'hDEAD_BEEF},
      '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 4'h1, 32'h0},
      '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 4'h0, 32'hDEAD_BEAA},
      '{1'b1, 32'h0000_1FFC, 32'h1122_3344, 4'hC, 4'hC, 32'h0},
      '{1'b0, 32'h0000_1FFC, 32'h0,         4'h0, 4'h0, 32'h1122_0000},
      '{1'b0, 32'hFFFF_E010, 32'h0,         4'h0, 4'h0, 32'hDEAD_BEAA},
      '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'h6, 4'h6, 32'h0},
      '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 4'h0, 32'h00FE_F000},
      '{1'b1, 32'h2000_0010, 32'h5555_5555, 4'h8, 4'h8, 32'h0},
      '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 4'h0, 32'h55AD_BEAA}
    };
    bus.mem_valid = 1'b0;
    bus.mem_sel   = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, bus.mem_ready}, 32'h0);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    chk("rst_ce", {31'b0, ram_ce}, 32'h0);
    chk("rst_wre", {28'b0, ram_wre}, 32'h0);
    chk("rst_ad", {21'b0, ram_ad}, 32'h0);
    chk("rst_din", ram_din, 32'h0);
    chk("rst_oce", {31'b0, ram_oce}, 32'h1);
`ifdef BOOTRAM_WP_EN
    chk("rst_wp_err", {31'b0, wp_err}, 32'h0);
`endif
    repeat (10) begin
      @(negedge clk);
      chk("idle_ready", {31'b0, bus.mem_ready}, 32'h0);
    end
    for (int i = 0; i < 11; i++)
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_wre, vecs[i].exp_rdata);
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b1;
    bus.mem_sel   = 1'b0;
    bus.mem_addr  = 32'h10;
    repeat (5) begin
      @(negedge clk);
      chk("nosel_ce", {31'b0, ram_ce}, 32'h0);
      chk("nosel_ready", {31'b0, bus.mem_ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b1;
    bus.mem_sel   = 1'b1;
    bus.mem_addr  = 32'h24;
    bus.mem_wstrb = 4'h0;
    st = cyc;
    @(posedge clk);
    #1 bus.mem_valid = 1'b0;
    bus.mem_sel = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_in_capture", {31'b0, cyc == st + 2}, 32'h1);
    @(negedge clk);
    chk("abort_ready", {31'b0, bus.mem_ready}, 32'h0);
    chk("abort_state", {30'b0, dut.state}, {30'b0, IDLE});
    chk("abort_wre", {28'b0, ram_wre}, 32'h0);
    chk("abort_rdata", bus.mem_rdata, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_abort_ready", {31'b0, bus.mem_ready}, 32'h0);
    txn(1'b0, 32'h24, 32'h0, 4'h0, 4'h0, 32'h00FE_F000);
`ifdef BOOTRAM_WP_EN
    txn(1'b1, 32'h20, 32'hA5A5_A5A5, 4'hF, 4'hF, 32'h0, 1'b0);
    txn(1'b1, 32'h20, 32'h1234_5678, 4'hF, 4'h0, 32'h0, 1'b1);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 4'h0, 32'hA5A5_A5A5, 1'b1);
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
